// File: rtl/muldiv_unit.sv
// HI/LO producer for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Two-cycle multiply, 32-iteration restoring divide, single-cycle write pulse.
module muldiv_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic [1:0]  hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] a_q, b_q, rem, quo;
  logic        sgn, sign_q, sign_r, dz;

  logic        go, is_mul, is_div, is_mthi, is_mtlo, last;
  logic [1:0]  we_nx;
  logic [31:0] hi_nx, lo_nx;
  logic [63:0] prod;
  logic [32:0] rem_sh, diff;
  logic        ge;
  logic [31:0] rem_nx, quo_nx;

  assign go      = start && !flush;
  assign is_mul  = (op == 3'b001) || (op == 3'b010);
  assign is_div  = (op == 3'b011) || (op == 3'b100);
  assign is_mthi = (op == 3'b101);
  assign is_mtlo = (op == 3'b110);
  assign last    = (cnt == 5'(DIV_ITERS - 1));

  assign busy = (state == MUL) || (state == DIV) ||
                (state == IDLE && go && (is_mul || is_div));

  // Sign-extend only for MULT; the low 64 bits are then exact either way.
  assign prod = {{32{sgn & a_q[31]}}, a_q} * {{32{sgn & b_q[31]}}, b_q};

  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, b_q};
  assign ge     = !diff[32];
  assign rem_nx = ge ? diff[31:0] : rem_sh[31:0];
  assign quo_nx = {quo[30:0], ge};

  always_comb begin
    state_nx = state;
    we_nx    = 2'b00;
    hi_nx    = hi_out;
    lo_nx    = lo_out;
    unique case (state)
      IDLE: begin
        if (go) begin
          unique case (1'b1)
            is_mul:  state_nx = MUL;
            is_div:  state_nx = DIV;
            is_mthi: begin
              we_nx = 2'b10;
              hi_nx = src_a;
            end
            is_mtlo: begin
              we_nx = 2'b01;
              lo_nx = src_a;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (flush) begin
          state_nx = IDLE;
        end else begin
          state_nx = WB;
          we_nx    = 2'b11;
          hi_nx    = prod[63:32];
          lo_nx    = prod[31:0];
        end
      end
      DIV: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (last) begin
          state_nx = WB;
          we_nx    = 2'b11;
          if (dz) begin
            hi_nx = a_q;
            lo_nx = 32'hFFFF_FFFF;
          end else begin
            hi_nx = sign_r ? -rem_nx : rem_nx;
            lo_nx = sign_q ? -quo_nx : quo_nx;
          end
        end
      end
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hilo_we <= 2'b00;
      hi_out  <= '0;
      lo_out  <= '0;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem     <= '0;
      quo     <= '0;
      sgn     <= 1'b0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dz      <= 1'b0;
    end else begin
      state   <= state_nx;
      hilo_we <= we_nx;
      hi_out  <= hi_nx;
      lo_out  <= lo_nx;
      if (state == IDLE && go && is_mul) begin
        a_q <= src_a;
        b_q <= src_b;
        sgn <= (op == 3'b001);
      end
      if (state == IDLE && go && is_div) begin
        sgn    <= (op == 3'b011);
        a_q    <= src_a;
        quo    <= (op == 3'b011 && src_a[31]) ? -src_a : src_a;
        b_q    <= (op == 3'b011 && src_b[31]) ? -src_b : src_b;
        sign_q <= (op == 3'b011) && (src_a[31] ^ src_b[31]);
        sign_r <= (op == 3'b011) && src_a[31];
        dz     <= (src_b == 32'd0);
        rem    <= '0;
        cnt    <= '0;
      end
      if (state == DIV) begin
        if (flush) begin
          cnt <= '0;
        end else begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= last ? 5'd0 : cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
// Inputs change and outputs are sampled around the falling edge.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [1:0]  hilo_we;
  logic [31:0] hi_out, lo_out;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .flush   (flush),
    .busy    (busy),
    .hilo_we (hilo_we),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Issue at cycle t, expect the write pulse at t+lat.
  task automatic run(input string tag, input logic [2:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [1:0] ewe,
                     input logic [31:0] ehi, input logic [31:0] elo,
                     input bit hold);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 chk({tag, ".busy0"}, 64'(busy), 64'(lat > 1));
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      start = hold && (k == 1);
      op = hold ? OP_DIV : o;
      #1;
      chk({tag, ".busy"}, 64'(busy), 64'd1);
      chk({tag, ".we_early"}, 64'(hilo_we), 64'd0);
    end
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    #1;
    chk({tag, ".we"}, 64'(hilo_we), 64'(ewe));
    chk({tag, ".busy_wb"}, 64'(busy), 64'd0);
    if (ewe[1]) chk({tag, ".hi"}, 64'(hi_out), 64'(ehi));
    if (ewe[0]) chk({tag, ".lo"}, 64'(lo_out), 64'(elo));
    @(negedge clk);
    #1;
    chk({tag, ".we_after"}, 64'(hilo_we), 64'd0);
    chk({tag, ".busy_after"}, 64'(busy), 64'd0);
  endtask

  // DIV 100/7 aborted at t+10 by flush (use_rst=0) or reset (use_rst=1).
  task automatic abort(input string tag, input bit use_rst);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0; op = 3'b000;
      if (use_rst) rst = (k == 10);
      else flush = (k == 10);
      #1;
      if (k <= 10) chk({tag, ".busy_pre"}, 64'(busy), 64'd1);
      else chk({tag, ".busy_post"}, 64'(busy), 64'd0);
      chk({tag, ".we"}, 64'(hilo_we), 64'd0);
    end
    flush = 1'b0;
    rst = 1'b0;
    if (use_rst) begin
      chk({tag, ".hi_rst"}, 64'(hi_out), 64'd0);
      chk({tag, ".lo_rst"}, 64'(lo_out), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.we", 64'(hilo_we), 64'd0);
    chk("rst.hi", 64'(hi_out), 64'd0);
    chk("rst.lo", 64'(lo_out), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    rst = 1'b0;

    run("mult", OP_MULT, 32'hFFFF_FFFF, 32'h2, 2, 2'b11,
        32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 2, 2'b11,
        32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    run("div_n7_2", OP_DIV, 32'hFFFF_FFF9, 32'h2, 33, 2'b11,
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("div_7_n2", OP_DIV, 32'h7, 32'hFFFF_FFFE, 33, 2'b11,
        32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 2'b11,
        32'h2, 32'hE, 1'b0);
    run("divu_dz", OP_DIVU, 32'h1234_5678, 32'h0, 33, 2'b11,
        32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    run("div_dz", OP_DIV, 32'hFFFF_FFF9, 32'h0, 33, 2'b11,
        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    run("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 2'b11,
        32'h0, 32'h8000_0000, 1'b0);
    run("mthi", OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1, 2'b10,
        32'hDEAD_BEEF, 32'h0, 1'b0);
    run("mtlo", OP_MTLO, 32'h0000_CAFE, 32'h0, 1, 2'b01,
        32'h0, 32'h0000_CAFE, 1'b0);

    @(negedge clk);
    start = 1'b1; op = OP_MTHI; src_a = 32'h5555_AAAA; flush = 1'b1;
    #1 chk("flush_idle.busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_idle.we", 64'(hilo_we), 64'd0);
    chk("flush_idle.hi", 64'(hi_out), 64'hDEAD_BEEF);

    abort("flush", 1'b0);
    abort("reset", 1'b1);

    run("post_rst_mult", OP_MULT, 32'd6, 32'hFFFF_FFFD, 2, 2'b11,
        32'hFFFF_FFFF, 32'hFFFF_FFEE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
